// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Branch controller around the EX-stage comparator. It sets the comparator
// mode (BrUn) from funct3, turns BrEQ/BrLT into a taken/not-taken outcome,
// predicts IF branches from a direct-mapped table of 2-bit saturating
// counters, issues a one-cycle registered redirect/flush on a misprediction,
// and counts resolved branches and mispredictions.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   if_pc, if_is_branch, if_imm
//                     IF instruction info used for prediction
//   pred_taken, pred_target
//                     combinational IF prediction and target (if_pc + if_imm)
//   ex_valid, ex_is_branch, ex_funct3, ex_pc, ex_target, ex_pred_taken,
//   ex_stall          EX instruction info used for resolution
//   BrUn              comparator mode (combinational from ex_funct3)
//   BrEQ, BrLT        comparator results
//   redirect_valid, redirect_pc, flush
//                     registered correct-path redirect, high for one cycle
//   br_count, mispred_count
//                     wrapping 32-bit statistics counters
//
// States
//   state | meaning
//   RUN   | normal operation, EX branches are resolved
//   FLUSH | redirect cycle, EX contents are wrong-path and ignored
// -----------------------------------------------------------------------------

`ifndef BrUn_UNSIGNED
`define BrUn_UNSIGNED 1'b1
`endif
`ifndef BrUn_SIGNED
`define BrUn_SIGNED 1'b0
`endif
`ifndef BrEQ_BEQ
`define BrEQ_BEQ 1'b1
`endif
`ifndef BrEQ_BNE
`define BrEQ_BNE 1'b0
`endif
`ifndef BrLT_BLT
`define BrLT_BLT 1'b1
`endif
`ifndef BrLT_BGE
`define BrLT_BGE 1'b0
`endif

module branch_resolve_ctrl #(
   parameter int IDX_W = 4,
   parameter int XLEN  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] if_pc,
   input  logic            if_is_branch,
   input  logic [XLEN-1:0] if_imm,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            ex_valid,
   input  logic            ex_is_branch,
   input  logic [2:0]      ex_funct3,
   input  logic [XLEN-1:0] ex_pc,
   input  logic [XLEN-1:0] ex_target,
   input  logic            ex_pred_taken,
   input  logic            ex_stall,
   output logic            BrUn,
   input  logic            BrEQ,
   input  logic            BrLT,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            flush,
   output logic [31:0]     br_count,
   output logic [31:0]     mispred_count
);

   localparam int N_ENTRIES = 1 << IDX_W;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        bht_q [N_ENTRIES];
   logic [1:0]        bht_d [N_ENTRIES];
   logic              redirect_valid_q, redirect_valid_d;
   logic              flush_q, flush_d;
   logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;
   logic [31:0]       br_count_q, br_count_d;
   logic [31:0]       mispred_count_q, mispred_count_d;

   logic [IDX_W-1:0]  if_idx;
   logic [IDX_W-1:0]  ex_idx;
   logic              actual_taken;
   logic              resolve;
   logic              mispredict;
   logic [XLEN-1:0]   ex_pc_plus4;

   // ---------------------------------------------------------------------
   // IF-side prediction; reads the registered table, so a same-cycle
   // update at this index is not visible until the next cycle.
   // ---------------------------------------------------------------------
   assign if_idx      = if_pc[IDX_W+1:2];
   assign ex_idx      = ex_pc[IDX_W+1:2];
   assign pred_taken  = if_is_branch & bht_q[if_idx][1];
   assign pred_target = if_pc + if_imm;

   // ---------------------------------------------------------------------
   // EX-side comparator control and outcome decode
   // ---------------------------------------------------------------------
   assign BrUn = ex_funct3[1] ? `BrUn_UNSIGNED : `BrUn_SIGNED;

   always_comb begin
      actual_taken = 1'b0;
      case (ex_funct3)
         3'b000:          actual_taken = (BrEQ == `BrEQ_BEQ);
         3'b001:          actual_taken = (BrEQ == `BrEQ_BNE);
         3'b100, 3'b110:  actual_taken = (BrLT == `BrLT_BLT);
         3'b101, 3'b111:  actual_taken = (BrLT == `BrLT_BGE);
         // 010/011 are not real branches; they resolve as not taken
         default:         actual_taken = 1'b0;
      endcase
   end

   assign resolve     = ex_valid & ex_is_branch & ~ex_stall & (state_q == RUN);
   assign mispredict  = resolve & (actual_taken != ex_pred_taken);
   assign ex_pc_plus4 = ex_pc + XLEN'(4);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d          = state_q;
      redirect_valid_d = 1'b0;
      flush_d          = 1'b0;
      redirect_pc_d    = redirect_pc_q;
      br_count_d       = br_count_q;
      mispred_count_d  = mispred_count_q;
      bht_d            = bht_q;

      case (state_q)
         RUN: begin
            if (mispredict) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      // mispredict already implies RUN, so redirect flags are high only
      // in the cycle spent in FLUSH
      if (mispredict) begin
         redirect_valid_d = 1'b1;
         flush_d          = 1'b1;
         redirect_pc_d    = actual_taken ? ex_target : ex_pc_plus4;
         mispred_count_d  = mispred_count_q + 32'd1;
      end

      if (resolve) begin
         br_count_d = br_count_q + 32'd1;
         if (actual_taken) begin
            if (bht_q[ex_idx] != 2'b11) begin
               bht_d[ex_idx] = bht_q[ex_idx] + 2'b01;
            end
         end else begin
            if (bht_q[ex_idx] != 2'b00) begin
               bht_d[ex_idx] = bht_q[ex_idx] - 2'b01;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q          <= RUN;
         redirect_valid_q <= 1'b0;
         flush_q          <= 1'b0;
         redirect_pc_q    <= '0;
         br_count_q       <= '0;
         mispred_count_q  <= '0;
         for (int i = 0; i < N_ENTRIES; i++) begin
            bht_q[i] <= 2'b01;
         end
      end else begin
         state_q          <= state_d;
         redirect_valid_q <= redirect_valid_d;
         flush_q          <= flush_d;
         redirect_pc_q    <= redirect_pc_d;
         br_count_q       <= br_count_d;
         mispred_count_q  <= mispred_count_d;
         bht_q            <= bht_d;
      end
   end

   assign redirect_valid = redirect_valid_q;
   assign flush          = flush_q;
   assign redirect_pc    = redirect_pc_q;
   assign br_count       = br_count_q;
   assign mispred_count  = mispred_count_q;

endmodule
